// File: rtl/memoria_dados_pkg.sv
// Shared types and helpers for the parametrised data memory.
package memoria_dados_pkg;

    typedef enum logic {
        LIMPANDO,
        PRONTO
    } estado_t;

    localparam int DATA_W_PADRAO = 32;
    localparam int DEPTH_PADRAO  = 128;

    // Byte merge: keeps the old byte unless its enable is set.
    function automatic logic [7:0] mescla_byte(input logic [7:0] velho,
                                               input logic [7:0] novo,
                                               input logic       hab);
        return hab ? novo : velho;
    endfunction

endpackage

// File: rtl/memoria_dados_param_if.sv
// Load/store bus between the datapath and the data RAM.
// Optional macro MEMDADOS_CONTADORES_EN adds the request counters.
interface memoria_dados_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  leituraReq;
    logic [ADDR_W-1:0]     enderecoLeitura;
    logic [DATA_W-1:0]     dadoLeitura;
    logic                  leituraValida;
    logic                  escritaReq;
    logic [ADDR_W-1:0]     enderecoEscrita;
    logic [DATA_W-1:0]     dadoEscrita;
    logic [DATA_W/8-1:0]   habilitaByte;
    logic                  pronto;
    logic                  erroEndereco;
`ifdef MEMDADOS_CONTADORES_EN
    logic [31:0]           contLeituras;
    logic [31:0]           contEscritas;
`endif

    modport master (
        output leituraReq, enderecoLeitura, escritaReq, enderecoEscrita,
        output dadoEscrita, habilitaByte,
`ifdef MEMDADOS_CONTADORES_EN
        input  contLeituras, contEscritas,
`endif
        input  dadoLeitura, leituraValida, pronto, erroEndereco
    );

    modport slave (
        input  leituraReq, enderecoLeitura, escritaReq, enderecoEscrita,
        input  dadoEscrita, habilitaByte,
`ifdef MEMDADOS_CONTADORES_EN
        output contLeituras, contEscritas,
`endif
        output dadoLeitura, leituraValida, pronto, erroEndereco
    );
endinterface

// File: rtl/memoria_dados_banco.sv
// Raw DEPTH x DATA_W storage: byte-enabled synchronous write, combinational read, no reset.
module memoria_dados_banco
    import memoria_dados_pkg::*;
#(
    parameter int DATA_W = DATA_W_PADRAO,
    parameter int DEPTH  = DEPTH_PADRAO,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic                escreve,
    input  logic [IDX_W-1:0]    idx_escrita,
    input  logic [DATA_W-1:0]   dado_escrita,
    input  logic [DATA_W/8-1:0] hab_byte,
    input  logic [IDX_W-1:0]    idx_leitura,
    output logic [DATA_W-1:0]   dado_leitura
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-enabled word write
    always_ff @(posedge clock) begin
        if (escreve) begin
            for (int unsigned i = 0; i < DATA_W / 8; i++) begin
                mem[idx_escrita][8*i +: 8] <= mescla_byte(mem[idx_escrita][8*i +: 8],
                                                          dado_escrita[8*i +: 8],
                                                          hab_byte[i]);
            end
        end
    end

    // Asynchronous read of the current contents
    always_comb begin
        dado_leitura = mem[idx_leitura];
    end
endmodule

// File: rtl/memoria_dados_param.sv
// Processor data RAM: post-reset clearing FSM, range checks, forwarding, registered read.
// Optional macro MEMDADOS_CONTADORES_EN adds saturating read/write counters.
module memoria_dados_param
    import memoria_dados_pkg::*;
#(
    parameter int DATA_W  = DATA_W_PADRAO,
    parameter int DEPTH   = DEPTH_PADRAO,
    parameter int ADDR_W  = 32,
    parameter int FORWARD = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    memoria_dados_param_if.slave bus
);
    localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LIMITE     = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  IDX_ULTIMO = IDX_W'(DEPTH - 1);

    estado_t               estado, prox_estado;
    logic [IDX_W-1:0]      idx;
    logic                  em_pronto;
    logic                  leitura_ok, escrita_ok, leitura_aceita, escrita_aceita, erro;
    logic                  banco_escreve;
    logic [IDX_W-1:0]      banco_idx;
    logic [DATA_W-1:0]     banco_dado;
    logic [DATA_W/8-1:0]   banco_hab;
    logic [DATA_W-1:0]     dado_banco, dado_lido;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= LIMPANDO;
        else       estado <= prox_estado;
    end

    // Next state: clear every word once, then stay ready until reset
    always_comb begin
        prox_estado = estado;
        em_pronto   = 1'b0;
        case (estado)
            LIMPANDO: if (idx == IDX_ULTIMO) prox_estado = PRONTO;
            PRONTO:   em_pronto = 1'b1;
            default:  prox_estado = LIMPANDO;
        endcase
    end

    assign bus.pronto = em_pronto;

    // Clear index walks 0..DEPTH-1 while clearing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) idx <= '0;
        else if (estado == LIMPANDO && idx != IDX_ULTIMO) idx <= idx + 1'b1;
    end

    // Full-width range checks and request acceptance
    always_comb begin
        leitura_ok     = {1'b0, bus.enderecoLeitura} < LIMITE;
        escrita_ok     = {1'b0, bus.enderecoEscrita} < LIMITE;
        leitura_aceita = em_pronto && bus.leituraReq;
        escrita_aceita = em_pronto && bus.escritaReq;
        erro           = (leitura_aceita && !leitura_ok) || (escrita_aceita && !escrita_ok);
    end

    // Bank write port: clearing owns it until ready
    always_comb begin
        if (estado == LIMPANDO) begin
            banco_escreve = 1'b1;
            banco_idx     = idx;
            banco_dado    = '0;
            banco_hab     = '1;
        end else begin
            banco_escreve = escrita_aceita && escrita_ok;
            banco_idx     = bus.enderecoEscrita[IDX_W-1:0];
            banco_dado    = bus.dadoEscrita;
            banco_hab     = bus.habilitaByte;
        end
    end

    memoria_dados_banco #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_banco (
        .clock        (clock),
        .escreve      (banco_escreve),
        .idx_escrita  (banco_idx),
        .dado_escrita (banco_dado),
        .hab_byte     (banco_hab),
        .idx_leitura  (bus.enderecoLeitura[IDX_W-1:0]),
        .dado_leitura (dado_banco)
    );

    // The bank read is pre-write; forwarding overlays the enabled new bytes
    if (FORWARD != 0) begin : g_forward
        // Merge same-address write data into the read path
        always_comb begin
            dado_lido = dado_banco;
            if (escrita_aceita && escrita_ok && bus.enderecoEscrita == bus.enderecoLeitura) begin
                for (int unsigned i = 0; i < DATA_W / 8; i++) begin
                    dado_lido[8*i +: 8] = mescla_byte(dado_banco[8*i +: 8],
                                                      bus.dadoEscrita[8*i +: 8],
                                                      bus.habilitaByte[i]);
                end
            end
        end
    end else begin : g_sem_forward
        // Old data only
        always_comb begin
            dado_lido = dado_banco;
        end
    end

    // Registered read data, valid strobe and address error pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.dadoLeitura   <= '0;
            bus.leituraValida <= 1'b0;
            bus.erroEndereco  <= 1'b0;
        end else begin
            bus.leituraValida <= leitura_aceita;
            bus.erroEndereco  <= erro;
            if (leitura_aceita) bus.dadoLeitura <= leitura_ok ? dado_lido : '0;
        end
    end

`ifdef MEMDADOS_CONTADORES_EN
    // Saturating counters of accepted in-range requests
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.contLeituras <= '0;
            bus.contEscritas <= '0;
        end else begin
            if (leitura_aceita && leitura_ok && bus.contLeituras != '1)
                bus.contLeituras <= bus.contLeituras + 32'd1;
            if (escrita_aceita && escrita_ok && bus.contEscritas != '1)
                bus.contEscritas <= bus.contEscritas + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_memoria_dados_param.sv
// Scoreboard bench: two instances (FORWARD=1 and FORWARD=0) share stimulus.
// Optional macro MEMDADOS_CONTADORES_EN enables the counter checks.
module tb_memoria_dados_param;
    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int AW  = 32;

    typedef struct {
        int unsigned ciclo;
        logic [31:0] dado;
        logic        valida;
        logic        erro;
    } resp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic [31:0] rd_end = '0, wr_end = '0, wr_dado = '0;
    logic [3:0]  wr_hab = '0;

    int unsigned ciclo = 0;
    int unsigned bordas = 0;
    int unsigned n_ok = 0, n_total = 0;
    int unsigned cont_lei = 0, cont_esc = 0;
    logic [31:0] mem_ref [DEP];
    resp_t q_fwd[$];
    resp_t q_old[$];

    memoria_dados_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_fwd ();
    memoria_dados_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_old ();

    assign if_fwd.leituraReq = rd_req;      assign if_old.leituraReq = rd_req;
    assign if_fwd.enderecoLeitura = rd_end; assign if_old.enderecoLeitura = rd_end;
    assign if_fwd.escritaReq = wr_req;      assign if_old.escritaReq = wr_req;
    assign if_fwd.enderecoEscrita = wr_end; assign if_old.enderecoEscrita = wr_end;
    assign if_fwd.dadoEscrita = wr_dado;    assign if_old.dadoEscrita = wr_dado;
    assign if_fwd.habilitaByte = wr_hab;    assign if_old.habilitaByte = wr_hab;

    memoria_dados_param #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .FORWARD(1)) dut_fwd (
        .clock (clock), .reset (reset), .bus (if_fwd));
    memoria_dados_param #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .FORWARD(0)) dut_old (
        .clock (clock), .reset (reset), .bus (if_old));

    always #5 clock = ~clock;
    always @(posedge clock) ciclo <= ciclo + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic verifica(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_total++;
        if (atual === esperado) n_ok++;
        else $display("FAIL %s actual=%0h required=%0h", nome, atual, esperado);
    endtask

    task automatic monitora(input int sel, input logic valida, input logic erro, input logic [31:0] dado);
        resp_t r;
        string nome;
        nome = (sel == 0) ? "fwd" : "old";
        if (!(valida || erro)) return;
        if ((sel == 0 && q_fwd.size() == 0) || (sel == 1 && q_old.size() == 0)) begin
            n_total++;
            $display("FAIL %s_unexpected_pulse actual valid=%0b err=%0b required none", nome, valida, erro);
            return;
        end
        r = (sel == 0) ? q_fwd.pop_front() : q_old.pop_front();
        verifica({nome, "_cycle"}, 64'(ciclo), 64'(r.ciclo));
        verifica({nome, "_valid"}, 64'(valida), 64'(r.valida));
        verifica({nome, "_err"}, 64'(erro), 64'(r.erro));
        if (r.valida) verifica({nome, "_data"}, 64'(dado), 64'(r.dado));
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            monitora(0, if_fwd.leituraValida, if_fwd.erroEndereco, if_fwd.dadoLeitura);
            monitora(1, if_old.leituraValida, if_old.erroEndereco, if_old.dadoLeitura);
        end
    end

    // One clock of stimulus; the reference model predicts the response from the memory rules.
    task automatic passo(input logic rd, input logic [31:0] ra, input logic wr,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] mascara, velho, novo;
        logic rok, wok, e;
        resp_t r;
        rd_req = rd; rd_end = ra; wr_req = wr; wr_end = wa; wr_dado = wd; wr_hab = be;
        if (bordas >= DEP) begin
            mascara = '0;
            for (int i = 0; i < 4; i++) if (be[i]) mascara = mascara | (32'hFF << (8 * i));
            rok = ra < 32'(DEP);
            wok = wa < 32'(DEP);
            e = (rd && !rok) || (wr && !wok);
            if (rd || e) begin
                velho = (rd && rok) ? mem_ref[ra] : '0;
                novo = velho;
                if (rd && rok && wr && wok && wa == ra) novo = (velho & ~mascara) | (wd & mascara);
                r.ciclo = ciclo + 1; r.valida = rd; r.erro = e;
                r.dado = novo;  q_fwd.push_back(r);
                r.dado = velho; q_old.push_back(r);
            end
            if (wr && wok) begin
                mem_ref[wa] = (mem_ref[wa] & ~mascara) | (wd & mascara);
                if (cont_esc != 32'hFFFF_FFFF) cont_esc++;
            end
            if (rd && rok && cont_lei != 32'hFFFF_FFFF) cont_lei++;
        end
        @(posedge clock); #1;
        bordas++;
        verifica("pronto_fwd", 64'(if_fwd.pronto), 64'(bordas >= DEP));
        verifica("pronto_old", 64'(if_old.pronto), 64'(bordas >= DEP));
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) passo(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic drenar();
        for (int k = 0; k < 20 && (q_fwd.size() != 0 || q_old.size() != 0); k++) ocioso(1);
        ocioso(1);
        if (q_fwd.size() != 0 || q_old.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout actual pending=%0d required 0", q_fwd.size() + q_old.size());
            q_fwd.delete(); q_old.delete();
        end
    endtask

    task automatic aplica_reset();
        reset = 1'b1;
        #1;
        verifica("reset_pronto_fwd", 64'(if_fwd.pronto), 64'd0);
        verifica("reset_pronto_old", 64'(if_old.pronto), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        bordas = 0;
        cont_lei = 0; cont_esc = 0;
        for (int i = 0; i < DEP; i++) mem_ref[i] = '0;
    endtask

    task automatic verifica_contadores();
`ifdef MEMDADOS_CONTADORES_EN
        verifica("cont_leituras", 64'(if_fwd.contLeituras), 64'(cont_lei));
        verifica("cont_escritas", 64'(if_fwd.contEscritas), 64'(cont_esc));
`endif
    endtask

    initial begin
        logic [31:0] ra, wa;
        for (int i = 0; i < DEP; i++) mem_ref[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        verifica("rst_data", 64'(if_fwd.dadoLeitura), 64'd0);
        verifica("rst_valid", 64'(if_fwd.leituraValida), 64'd0);
        verifica("rst_err", 64'(if_old.erroEndereco), 64'd0);
        verifica("rst_pronto", 64'(if_old.pronto), 64'd0);
        reset = 1'b0;
        bordas = 0;

        // Clearing: requests during the clear must be ignored
        for (int i = 0; i < DEP; i++) passo(1'b1, 32'(i), 1'b1, 32'(i), 32'hDEAD_BEEF, 4'hF);
        ocioso(2);
        for (int i = 0; i < DEP; i++) passo(1'b1, 32'(i), 1'b0, '0, '0, '0);
        drenar();

        // Byte enables
        passo(1'b0, '0, 1'b1, 32'd3, 32'hAABB_CCDD, 4'b1111);
        passo(1'b0, '0, 1'b1, 32'd3, 32'h1122_3344, 4'b0101);
        passo(1'b1, 32'd3, 1'b0, '0, '0, '0);
        passo(1'b0, '0, 1'b1, 32'd3, 32'hFFFF_FFFF, 4'b0000);
        passo(1'b1, 32'd3, 1'b0, '0, '0, '0);
        drenar();

        // Same-cycle read/write forwarding
        passo(1'b0, '0, 1'b1, 32'd5, 32'h0, 4'hF);
        passo(1'b1, 32'd5, 1'b1, 32'd5, 32'hFFFF_FFFF, 4'b0011);
        passo(1'b1, 32'd5, 1'b0, '0, '0, '0);
        drenar();

        // Out of range, no wrap, combined error
        passo(1'b0, '0, 1'b1, 32'd16, 32'h5, 4'hF);
        passo(1'b1, 32'd0, 1'b0, '0, '0, '0);
        passo(1'b1, 32'hFFFF_FFFF, 1'b0, '0, '0, '0);
        passo(1'b0, '0, 1'b1, 32'h1000_0003, 32'h7777_7777, 4'hF);
        passo(1'b1, 32'd3, 1'b0, '0, '0, '0);
        passo(1'b1, 32'h8000_0003, 1'b1, 32'h13, 32'h9, 4'hF);
        drenar();
        verifica_contadores();

        // Reset mid-operation and re-clear
        passo(1'b0, '0, 1'b1, 32'd2, 32'h1234_5678, 4'hF);
        passo(1'b1, 32'd2, 1'b0, '0, '0, '0);
        drenar();
        aplica_reset();
        for (int i = 0; i < 5; i++) passo(1'b1, 32'd2, 1'b1, 32'd2, 32'hCAFE_F00D, 4'hF);
        aplica_reset();
        for (int i = 0; i < DEP; i++) passo(1'b1, 32'd2, 1'b0, '0, '0, '0);
        passo(1'b1, 32'd2, 1'b0, '0, '0, '0);
        drenar();

        // Counters: 3 reads, 2 writes, 1 out-of-range read in total since reset
        passo(1'b1, 32'd7, 1'b1, 32'd7, 32'h0102_0304, 4'hF);
        passo(1'b1, 32'd7, 1'b1, 32'd8, 32'h0, 4'h0);
        passo(1'b1, 32'd99, 1'b0, '0, '0, '0);
        drenar();
        verifica_contadores();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEP + 2));
            wa = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEP + 2));
            if ($urandom_range(0, 3) == 0) wa = ra;
            passo(1'($urandom), ra, 1'($urandom), wa, $urandom, 4'($urandom));
        end
        drenar();
        verifica_contadores();

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end
endmodule

// File: doc/memoria_dados_param.md
Name: memoria_dados_param

Overview:
Parametrised successor to the single-port data memory. Width and depth are generic; one write port with byte enables; one read port with 1-cycle registered latency and a valid strobe. A post-reset clearing FSM zeroes the array and then asserts pronto; out-of-range addresses are flagged. Sits between the datapath's load/store unit and nothing else: it is the processor's data RAM.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
DEPTH, 128, number of words
ADDR_W, 32, address port width; the address is a word index, not a byte address
FORWARD, 1, 1 = read of the address being written in the same cycle returns new data; 0 = returns old data

Ports:
clock  in  1  single clock, all state updates on posedge
reset  in  1  asynchronous, active-high
leituraReq  in  1  read request, sampled on posedge
enderecoLeitura  in  ADDR_W  read word index
dadoLeitura  out  DATA_W  read data, registered
leituraValida  out  1  one-cycle pulse: dadoLeitura updated this cycle
escritaReq  in  1  write request, sampled on posedge
enderecoEscrita  in  ADDR_W  write word index
dadoEscrita  in  DATA_W  write data
habilitaByte  in  DATA_W/8  per-byte write enable; bit i covers dadoEscrita[8i+7:8i]
pronto  out  1  high when clearing is complete and requests are accepted
erroEndereco  out  1  one-cycle pulse: an accepted request had address >= DEPTH

Behaviour:
- Reset (asynchronous, active-high) forces FSM to LIMPANDO, clear index to 0, dadoLeitura=0, leituraValida=0, pronto=0, erroEndereco=0. Array contents are not reset directly.
- FSM LIMPANDO: writes 0 to word[idx] each cycle and increments idx. After idx=DEPTH-1 is written, the FSM goes to PRONTO. pronto rises on the first PRONTO cycle, exactly DEPTH cycles after the first clock edge with reset low.
- FSM PRONTO: the FSM stays there until reset. No other transitions exist.
- While in LIMPANDO, leituraReq and escritaReq are ignored. No valid or error pulse is produced, and nothing is queued.
- Write in PRONTO: on posedge with escritaReq=1 and enderecoEscrita<DEPTH, each byte with habilitaByte[i]=1 is updated and the others are kept. habilitaByte=0 is a legal no-op write.
- Read in PRONTO: with leituraReq=1 at posedge N, dadoLeitura holds word[enderecoLeitura] and leituraValida=1 during cycle N+1. dadoLeitura holds its last value when no read occurs. leituraValida is 0 whenever no read was accepted on the previous edge.
- Out of range (address >= DEPTH, compared at full ADDR_W width, with no truncation or wrap):
  - A write is dropped, the array is unchanged, and erroEndereco pulses the next cycle.
  - A read returns dadoLeitura=0 with leituraValida=1, and erroEndereco pulses.
  - If both ports are out of range in the same cycle, there is a single erroEndereco pulse.
- Same-cycle read and write to the same in-range address:
  - FORWARD=1: the read returns old data merged per byte with the enabled new bytes.
  - FORWARD=0: the read returns pre-write data.
- Back-to-back reads every cycle are supported at full throughput.
- Reset asserted mid-operation aborts everything immediately. Clearing restarts from idx 0 on release, and any array data is discarded by the re-clear.

Optional Feature:
MEMDADOS_CONTADORES_EN
- Defined: adds outputs contLeituras and contEscritas, 32 bits each.
  - Each counts accepted in-range requests in PRONTO.
  - Each saturates at all-ones and resets to 0 on reset.
  - A write with habilitaByte=0 still counts.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package memoria_dados_pkg: FSM state enum (LIMPANDO, PRONTO), the default DATA_W/DEPTH constants, and a byte-merge function (old, new, byte enables) shared by the write path and forwarding.
- Sub-module memoria_dados_banco: raw DEPTH x DATA_W array with byte-enabled synchronous write and combinational read, with no reset. The top level holds the FSM, range checks, forwarding, output registers and counters.

Test Plan:
- Clear sequence: DEPTH=16, release reset and count edges -> pronto=0 for 16 edges, then 1. Reading all 16 words -> 0.
- Byte-enable write: write 0xAABBCCDD to addr 3 with habilitaByte=4'b1111, then 0x11223344 with habilitaByte=4'b0101, then read 3 -> 0xAA22CC44 with leituraValida one cycle after the request.
- Forwarding: word 5=0x0; same cycle write 0xFFFFFFFF with habilitaByte=4'b0011 and read 5. FORWARD=1 -> 0x0000FFFF; FORWARD=0 -> 0x00000000, with a subsequent read giving 0x0000FFFF.
- Out of range: DEPTH=16, write addr 16 value 0x5 -> erroEndereco pulse, array unchanged. Read addr 0xFFFFFFFF -> dadoLeitura=0, leituraValida=1, erroEndereco=1 for exactly one cycle.
- Reset mid-operation: write 0x12345678 to addr 2 and assert reset for 1 cycle mid-clear of a second run -> pronto drops immediately; after re-clear, addr 2 reads 0. Requests issued during LIMPANDO produce no leituraValida.
- With MEMDADOS_CONTADORES_EN: 3 reads, 2 writes, 1 out-of-range read -> contLeituras=3, contEscritas=2.
